// File: rtl/mem_cmd_initiator.sv
// Command-FIFO-fed initiator for a single-port synchronous memory, returning read data in order.
// Optional address range check enabled by defining MEM_ADDR_CHK_EN.
module mem_cmd_initiator #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LatW = $clog2(RD_LAT + 1);
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  logic [EntW-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic              push, pop, empty, full;
  logic              head_wr, head_bad;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  state_e            state_q, state_d;
  logic              cmd_wr_q, cmd_wr_d, cmd_bad_q, cmd_bad_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rsp_data_q, rsp_data_d;
  logic              mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
  logic              rsp_valid_q, rsp_valid_d, busy_q, busy_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign {head_wr, head_addr, head_wdata} = fifo_mem_q[rd_ptr_q];

`ifdef MEM_ADDR_CHK_EN
  localparam logic [ADDR_W:0] MemDepthW = (ADDR_W + 1)'(MEM_DEPTH);
  logic err_q, err_d;
  assign head_bad = ({1'b0, head_addr} >= MemDepthW);
  assign err      = err_q;
`else
  logic unused_mem_depth;
  assign unused_mem_depth = ^MEM_DEPTH;
  assign head_bad         = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cmd_wr, cmd_addr, cmd_wdata};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + (PtrW + 1)'(1);
    else if (!push && pop) count_d = count_q - (PtrW + 1)'(1);
  end

  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_bad_d   = cmd_bad_q;
    cmd_addr_d  = cmd_addr_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    pop         = 1'b0;

    unique case (state_q)
      StIdle: pop = !empty;
      StIssue: begin
        if (cmd_wr_q) begin
          // Back-to-back writes: keep issuing while commands are queued.
          if (!empty) pop = 1'b1;
          else        state_d = StIdle;
        end else if (cmd_bad_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_addr_d  = cmd_addr_q;
          state_d     = StResp;
        end else begin
          lat_d   = LatW'(RD_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        lat_d = lat_q - LatW'(1);
        if (lat_q == LatW'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_rdata;
          rsp_addr_d  = cmd_addr_q;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are registered, so they are launched in the cycle the command is popped.
    if (pop) begin
      state_d    = StIssue;
      cmd_wr_d   = head_wr;
      cmd_bad_d  = head_bad;
      cmd_addr_d = head_addr;
      if (!head_bad) begin
        mem_wr_d   = head_wr;
        mem_rd_d   = !head_wr;
        mem_addr_d = head_addr;
        if (head_wr) mem_wdata_d = head_wdata;
      end
    end
`ifdef MEM_ADDR_CHK_EN
    err_d = err_q | (pop && head_bad);
`endif
  end

  assign busy_d = (state_d != StIdle) || (count_d != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      cmd_wr_q    <= 1'b0;
      cmd_bad_q   <= 1'b0;
      cmd_addr_q  <= '0;
      lat_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ADDR_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_bad_q   <= cmd_bad_d;
      cmd_addr_q  <= cmd_addr_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      busy_q      <= busy_d;
`ifdef MEM_ADDR_CHK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign busy      = busy_q;

endmodule
